keypad_scanner: RTL and testbench

Front-end stage of the safe: drives the 4×3 matrix keypad rows one at a time and samples the three column returns. It debounces and ghost-rejects the samples and hands the downstream safe logic one clean, held key as row/column levels, plus a key code and a one-cycle press strobe. Only one key is reported per press; a new report requires a full debounced release.

---
 rtl/keypad_scanner.sv | 211 +++++++++++++++++++++
 tb/tb_keypad_scanner.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_scanner.sv
// keypad_scanner: row-scanning front end for a 4x3 matrix keypad.
// Drives one keypad row at a time. Samples the column returns at the end of
// each row dwell and assembles a 12-bit sweep frame. A frame is accepted only
// after DEBOUNCE_SCANS identical sweeps. The accepted frame is then reduced
// to a single held key with one press strobe per key.
module keypad_scanner #(
  parameter int SCAN_DIV       = 500000,
  parameter int DEBOUNCE_SCANS = 3
) (
  input  logic       clk,
  input  logic       initialize,
  input  logic [2:0] col_raw,
  output logic [3:0] scan_row,
  output logic       row1,
  output logic       row2,
  output logic       row3,
  output logic       row4,
  output logic       col1,
  output logic       col2,
  output logic       col3,
  output logic [3:0] key_code,
  output logic       key_valid
);

  localparam int            DW         = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
  localparam logic [3:0]    DEB_MAX    = 4'(DEBOUNCE_SCANS);

  typedef enum logic {IDLE, PRESSED} state_t;

  // Maps a single-key frame (bit = row*3 + col) to the safe's key code.
  function automatic logic [3:0] encode_key(input logic [11:0] f);
    logic [3:0] code;
    case (f)
      12'h001: code = 4'd1;
      12'h002: code = 4'd2;
      12'h004: code = 4'd3;
      12'h008: code = 4'd4;
      12'h010: code = 4'd5;
      12'h020: code = 4'd6;
      12'h040: code = 4'd7;
      12'h080: code = 4'd8;
      12'h100: code = 4'd9;
      12'h200: code = 4'hA;
      12'h400: code = 4'h0;
      12'h800: code = 4'hB;
      default: code = 4'h0;
    endcase
    return code;
  endfunction

  // True when exactly one bit of the frame is set.
  function automatic logic is_single_key(input logic [11:0] f);
    return (f != 12'h000) && ((f & (f - 12'h001)) == 12'h000);
  endfunction

  logic [2:0]    col_s_p0;
  logic [2:0]    col_s;
  logic [DW-1:0] dwell_cnt;
  logic          tick;
  logic          sweep_end;
  logic [11:0]   frame_p1;
  logic [11:0]   frame_next;
  logic [11:0]   last_frame;
  logic [3:0]    match_cnt;
  logic [3:0]    match_cnt_next;
  logic [11:0]   deb_frame;
  logic          key_ok;
  logic [3:0]    hit_row;
  logic [2:0]    hit_col;
  logic [3:0]    held_row;
  logic [2:0]    held_col;
  state_t        state;

  // ---- stage p0: two-flop synchronizer for the asynchronous column returns
  always_ff @(posedge clk) begin
    if (initialize) begin
      col_s_p0 <= 3'b000;
      col_s    <= 3'b000;
    end else begin
      col_s_p0 <= col_raw;
      col_s    <= col_s_p0;
    end
  end

  // Dwell counter: one tick at the last cycle of every row dwell.
  always_ff @(posedge clk) begin
    if (initialize) begin
      dwell_cnt <= '0;
    end else if (tick) begin
      dwell_cnt <= '0;
    end else begin
      dwell_cnt <= dwell_cnt + 1'b1;
    end
  end

  assign tick      = (dwell_cnt == DWELL_LAST);
  assign sweep_end = tick && scan_row[3];

  // Row drive rotates row1 -> row4 -> row1 after each dwell has been sampled.
  always_ff @(posedge clk) begin
    if (initialize) begin
      scan_row <= 4'b0001;
    end else if (tick) begin
      scan_row <= {scan_row[2:0], scan_row[3]};
    end
  end

  // ---- stage p1: sweep frame assembly, one 3-bit slice per driven row
  // The frame with the current row's slice merged in. At sweep end this is
  // the complete frame, including the row4 slice sampled on that edge.
  always_comb begin
    frame_next = frame_p1;
    for (int r = 0; r < 4; r++) begin
      if (scan_row[r]) begin
        frame_next[r*3 +: 3] = col_s;
      end
    end
  end

  // Stores the sampled columns of the current row at the end of its dwell.
  always_ff @(posedge clk) begin
    if (initialize) begin
      frame_p1 <= 12'h000;
    end else if (tick) begin
      frame_p1 <= frame_next;
    end
  end

  // ---- stage p2: sweep-to-sweep debounce
  // Identical sweeps count up and saturate; any differing bit restarts at 1.
  always_comb begin
    if (frame_next != last_frame) begin
      match_cnt_next = 4'd1;
    end else if (match_cnt >= DEB_MAX) begin
      match_cnt_next = DEB_MAX;
    end else begin
      match_cnt_next = match_cnt + 4'd1;
    end
  end

  // Compares each completed sweep with the previous one and promotes it once stable.
  always_ff @(posedge clk) begin
    if (initialize) begin
      last_frame <= 12'h000;
      match_cnt  <= 4'd0;
      deb_frame  <= 12'h000;
    end else if (sweep_end) begin
      last_frame <= frame_next;
      match_cnt  <= match_cnt_next;
      if (match_cnt_next == DEB_MAX) begin
        deb_frame <= frame_next;
      end
    end
  end

  // Key qualification: ghosts and multi-presses (two or more bits) are not keys.
  always_comb begin
    key_ok = is_single_key(deb_frame);
    for (int r = 0; r < 4; r++) begin
      hit_row[r] = |deb_frame[r*3 +: 3];
    end
    for (int c = 0; c < 3; c++) begin
      hit_col[c] = deb_frame[c] | deb_frame[3 + c] | deb_frame[6 + c] | deb_frame[9 + c];
    end
  end

  // ---- stage p3: press/release FSM with registered key outputs
  // Reports a key once per press and holds it until a debounced full release.
  always_ff @(posedge clk) begin
    if (initialize) begin
      state     <= IDLE;
      held_row  <= 4'b0000;
      held_col  <= 3'b000;
      key_code  <= 4'h0;
      key_valid <= 1'b0;
    end else begin
      key_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (key_ok) begin
            state     <= PRESSED;
            key_code  <= encode_key(deb_frame);
            held_row  <= hit_row;
            held_col  <= hit_col;
            key_valid <= 1'b1;
          end
        end
        PRESSED: begin
          if (deb_frame == 12'h000) begin
            state    <= IDLE;
            held_row <= 4'b0000;
            held_col <= 3'b000;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign row1 = held_row[0];
  assign row2 = held_row[1];
  assign row3 = held_row[2];
  assign row4 = held_row[3];
  assign col1 = held_col[0];
  assign col2 = held_col[1];
  assign col3 = held_col[2];

endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: directed bench for keypad_scanner with a 4-cycle dwell
// and 2-sweep debounce (16-cycle sweep). A small keypad model routes the
// pressed-key matrix onto col_raw according to the driven row.
module tb_keypad_scanner;

  logic       clk;
  logic       initialize;
  logic [2:0] col_raw;
  logic [3:0] scan_row;
  logic       row1, row2, row3, row4;
  logic       col1, col2, col3;
  logic [3:0] key_code;
  logic       key_valid;

  // Pressed keys, bit index = row*3 + col (row/col counted from 0).
  logic [11:0] keys;

  int compared;
  int mismatched;
  int edge_n;
  int kv_cnt;
  int kv_edge;
  int clr_edge;
  logic [6:0] prev_held;

  keypad_scanner #(
    .SCAN_DIV(4),
    .DEBOUNCE_SCANS(2)
  ) dut (
    .clk(clk),
    .initialize(initialize),
    .col_raw(col_raw),
    .scan_row(scan_row),
    .row1(row1),
    .row2(row2),
    .row3(row3),
    .row4(row4),
    .col1(col1),
    .col2(col2),
    .col3(col3),
    .key_code(key_code),
    .key_valid(key_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Keypad matrix: a column reads high when a pressed key sits on the driven row.
  always_comb begin
    col_raw = 3'b000;
    for (int r = 0; r < 4; r++) begin
      if (scan_row[r]) begin
        col_raw = col_raw | keys[r*3 +: 3];
      end
    end
  end

  function automatic logic [6:0] held();
    return {row4, row3, row2, row1, col3, col2, col1};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advances one clock and samples just after the edge.
  task automatic step();
    logic [6:0] h;
    @(posedge clk);
    #1;
    edge_n++;
    if (key_valid === 1'b1) begin
      kv_cnt++;
      kv_edge = edge_n;
    end
    h = held();
    if (prev_held != 7'd0 && h == 7'd0) clr_edge = edge_n;
    prev_held = h;
  endtask

  task automatic run_to(input int target);
    while (edge_n < target) step();
  endtask

  task automatic do_reset(input int n);
    initialize = 1'b1;
    repeat (n) step();
    initialize = 1'b0;
    edge_n    = 0;
    kv_cnt    = 0;
    kv_edge   = -1;
    clr_edge  = -1;
    prev_held = 7'd0;
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    edge_n     = 0;
    kv_cnt     = 0;
    kv_edge    = -1;
    clr_edge   = -1;
    prev_held  = 7'd0;
    initialize = 1'b1;
    keys       = 12'h000;

    // Reset state and row rotation
    do_reset(3);
    chk("rst_scan_row", 32'(scan_row), 32'h1);
    chk("rst_key_valid", 32'(key_valid), 32'h0);
    chk("rst_held", 32'(held()), 32'h0);
    chk("rst_key_code", 32'(key_code), 32'h0);
    run_to(3);
    chk("rot_e3", 32'(scan_row), 32'h1);
    run_to(4);
    chk("rot_e4", 32'(scan_row), 32'h2);
    run_to(8);
    chk("rot_e8", 32'(scan_row), 32'h4);
    run_to(12);
    chk("rot_e12", 32'(scan_row), 32'h8);
    run_to(16);
    chk("rot_e16", 32'(scan_row), 32'h1);
    run_to(40);
    chk("idle_no_pulse", 32'(kv_cnt), 32'd0);
    chk("idle_held", 32'(held()), 32'h0);

    // Press and release key 5
    keys = 12'h010;
    do_reset(3);
    run_to(32);
    chk("p5_no_early_pulse", 32'(kv_cnt), 32'd0);
    run_to(33);
    chk("p5_pulse", 32'(key_valid), 32'h1);
    chk("p5_code", 32'(key_code), 32'h5);
    chk("p5_held", 32'(held()), 32'b0010010);
    run_to(34);
    chk("p5_pulse_width", 32'(key_valid), 32'h0);
    run_to(48);
    chk("p5_one_pulse", 32'(kv_cnt), 32'd1);
    chk("p5_still_held", 32'(held()), 32'b0010010);
    keys = 12'h000;
    run_to(80);
    chk("p5_held_before_clear", 32'(held()), 32'b0010010);
    run_to(81);
    chk("p5_cleared", 32'(held()), 32'h0);
    chk("p5_clear_edge", 32'(clr_edge), 32'd81);
    run_to(100);
    chk("p5_no_release_pulse", 32'(kv_cnt), 32'd1);
    chk("p5_code_kept", 32'(key_code), 32'h5);

    // Bounce: key 1 seen for one sweep only
    keys = 12'h000;
    do_reset(3);
    run_to(16);
    keys = 12'h001;
    run_to(32);
    keys = 12'h000;
    run_to(80);
    chk("bounce_no_pulse", 32'(kv_cnt), 32'd0);
    chk("bounce_held", 32'(held()), 32'h0);
    chk("bounce_code", 32'(key_code), 32'h0);

    // Ghost: keys 1 and 9 together, then 9 alone
    keys = 12'h101;
    do_reset(3);
    run_to(48);
    chk("ghost_no_pulse", 32'(kv_cnt), 32'd0);
    chk("ghost_held", 32'(held()), 32'h0);
    keys = 12'h100;
    run_to(80);
    chk("ghost_still_none", 32'(kv_cnt), 32'd0);
    run_to(96);
    chk("k9_one_pulse", 32'(kv_cnt), 32'd1);
    chk("k9_pulse_edge", 32'(kv_edge), 32'd81);
    chk("k9_code", 32'(key_code), 32'h9);
    chk("k9_held", 32'(held()), 32'b0100100);

    // Specials: * then #
    keys = 12'h200;
    do_reset(3);
    run_to(48);
    chk("star_pulse", 32'(kv_cnt), 32'd1);
    chk("star_edge", 32'(kv_edge), 32'd33);
    chk("star_code", 32'(key_code), 32'hA);
    chk("star_held", 32'(held()), 32'b1000001);
    keys = 12'h000;
    run_to(96);
    chk("star_released", 32'(held()), 32'h0);
    chk("star_clear_edge", 32'(clr_edge), 32'd81);
    chk("star_code_kept", 32'(key_code), 32'hA);
    keys = 12'h800;
    run_to(144);
    chk("hash_pulses", 32'(kv_cnt), 32'd2);
    chk("hash_edge", 32'(kv_edge), 32'd129);
    chk("hash_code", 32'(key_code), 32'hB);
    chk("hash_held", 32'(held()), 32'b1000100);

    // Reset mid-dwell while key 5 is held
    keys = 12'h010;
    do_reset(3);
    run_to(50);
    chk("mid_pre_held", 32'(held()), 32'b0010010);
    chk("mid_pre_pulse", 32'(kv_cnt), 32'd1);
    do_reset(1);
    chk("mid_rst_held", 32'(held()), 32'h0);
    chk("mid_rst_code", 32'(key_code), 32'h0);
    chk("mid_rst_scan_row", 32'(scan_row), 32'h1);
    chk("mid_rst_key_valid", 32'(key_valid), 32'h0);
    run_to(32);
    chk("mid_no_early_pulse", 32'(kv_cnt), 32'd0);
    chk("mid_code_zero", 32'(key_code), 32'h0);
    run_to(40);
    chk("mid_repulse", 32'(kv_cnt), 32'd1);
    chk("mid_repulse_edge", 32'(kv_edge), 32'd33);
    chk("mid_code", 32'(key_code), 32'h5);
    chk("mid_held", 32'(held()), 32'b0010010);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
